condition_unit: RTL
===================

// Module: condition_unit
// PURPOSE
//  Consumer of the ALU flag_generator outputs (N,Z,C,V) in the single-cycle ARMv4 core.
//  Holds the architectural NZCV status register and evaluates each instruction's 4-bit
//  condition field against it. Gates PCSrc/RegWrite/MemWrite so non-executing instructions
//  have no side effects.
//  Sits between the decoder/flag_generator and the PC/register-file/data-memory write ports.
// PARAMETERS
//  RESET_FLAGS  4'b0000  NZCV value loaded on reset, order {N,Z,C,V}
// PORTS
//  clk        in   1  core clock, rising edge active
//  rst_n      in   1  asynchronous, active-low reset
//  en         in   1  instruction-retire enable; 0 = stall, no flag update
//  Cond       in   4  instruction condition field Instr[31:28]
//  ALUFlags   in   4  {N,Z,C,V} from flag_generator for the current instruction
//  FlagW      in   2  decoder flag-write request: [1] = N,Z group; [0] = C,V group
//  PCS        in   1  decoder: instruction writes PC
//  RegW       in   1  decoder: instruction writes register file
//  MemW       in   1  decoder: instruction writes data memory
//  NoWrite    in   1  decoder: compare-class op (CMP/CMN/TST/TEQ); suppress RegWrite
//  PCSrc      out  1  gated PCS
//  RegWrite   out  1  gated RegW
//  MemWrite   out  1  gated MemW
//  CondEx     out  1  condition passed for the current instruction
//  Flags      out  4  registered NZCV {N,Z,C,V}
// BEHAVIOUR
//  - Reset (rst_n=0, async): Flags <= RESET_FLAGS immediately. Held while rst_n=0.
//    Outputs are combinational from Flags, so after reset CondEx follows Cond vs RESET_FLAGS.
//  - CondEx is combinational, evaluated against registered Flags (prior instruction's result).
//    Current ALUFlags are never used. Decode:
//    0000 EQ Z | 0001 NE !Z | 0010 CS C | 0011 CC !C | 0100 MI N | 0101 PL !N
//    0110 VS V | 0111 VC !V | 1000 HI C&!Z | 1001 LS !C|Z | 1010 GE N==V | 1011 LT N!=V
//    1100 GT !Z&(N==V) | 1101 LE Z|(N!=V) | 1110 AL 1 | 1111 NV 0.
//  - Gating (combinational, zero latency):
//    PCSrc = PCS&CondEx
//    RegWrite = RegW&CondEx&!NoWrite
//    MemWrite = MemW&CondEx
//    Outputs are not gated by en; the write ports honour en themselves.
//  - Flag update, rising clk, when en & CondEx:
//    FlagW[1] -> N,Z <= ALUFlags[3:2]; FlagW[0] -> C,V <= ALUFlags[1:0].
//    Groups are independent; FlagW=2'b00 holds all four bits.
//  - Stall: en=0 holds Flags unchanged regardless of FlagW/CondEx.
//  - A failed condition (incl. NV) never updates flags, even with FlagW=2'b11.
//  - Read-before-write: in the update cycle CondEx uses the old Flags.
//    The new value is visible from the next cycle.
//  - Reset asserted mid-stream overrides any same-edge update; first post-reset
//    instruction sees RESET_FLAGS.
//  - X on Cond with PCS/RegW/MemW=0 must not corrupt Flags when FlagW=0.
// STRUCTURE
//  - arm_cond_pkg: enum cond_e (EQ..NV, 4-bit); localparams FLAG_N=3, FLAG_Z=2,
//    FLAG_C=1, FLAG_V=0; typedef logic [3:0] nzcv_t.
//  - Sub-module cond_check: purely combinational (Cond, nzcv_t) -> CondEx. Unique-case
//    table, reused by a future pipelined core.
//  - Top: two always_ff groups (NZ, CV) with async negedge rst_n, plus gating assigns.
// TESTING
//  1. Reset: rst_n=0 with Flags previously 4'b1111 -> Flags=0000 with no clk edge.
//     Cond=0000 -> CondEx=0; Cond=1110 -> CondEx=1.
//  2. Split write: en=1, Cond=AL, FlagW=10, ALUFlags=1111 -> next Flags=1100.
//     Then FlagW=01, ALUFlags=0011 -> Flags=1111.
//  3. Full cond sweep: for each of 16 NZCV values x 16 Cond codes, compare CondEx with
//     the golden table. Check GT/LE at N=1,V=0,Z=0 (GT=0, LE=1).
//  4. Failed cond: Flags=0000, Cond=EQ, FlagW=11, RegW=MemW=PCS=1, ALUFlags=0100 ->
//     CondEx=0, all writes 0, Flags stay 0000.
//  5. Stall: en=0, Cond=AL, FlagW=11, ALUFlags=1010 -> Flags unchanged for 3 cycles.
//     en=1 -> Flags=1010 next edge.
//  6. CMP: Cond=AL, RegW=1, NoWrite=1, FlagW=11, ALUFlags=0110 -> RegWrite=0, Flags=0110.
//     Next instr Cond=EQ, PCS=1 -> PCSrc=1.

Source files
------------

// File: rtl/arm_cond_pkg.sv
// Shared types for ARM condition evaluation: condition codes and NZCV layout.
package arm_cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
        MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
        HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
        GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef logic [3:0] nzcv_t;

endpackage

// File: rtl/condition_unit_cond_check.sv
// Combinational ARM condition-field evaluator: (Cond, NZCV) -> pass/fail.
// Kept standalone so a pipelined core can reuse it at a different stage.
module cond_check
    import arm_cond_pkg::*;
(
    input  logic [3:0] i_cond,
    input  nzcv_t      i_flags,
    output logic       o_cond_ex
);

    logic w_n, w_z, w_c, w_v;

    assign w_n = i_flags[FLAG_N];
    assign w_z = i_flags[FLAG_Z];
    assign w_c = i_flags[FLAG_C];
    assign w_v = i_flags[FLAG_V];

    // Decode table; unknown codes fall back to "not executed" so nothing is written.
    always_comb begin
        o_cond_ex = 1'b0;
        unique case (cond_e'(i_cond))
            EQ: o_cond_ex = w_z;
            NE: o_cond_ex = ~w_z;
            CS: o_cond_ex = w_c;
            CC: o_cond_ex = ~w_c;
            MI: o_cond_ex = w_n;
            PL: o_cond_ex = ~w_n;
            VS: o_cond_ex = w_v;
            VC: o_cond_ex = ~w_v;
            HI: o_cond_ex = w_c & ~w_z;
            LS: o_cond_ex = ~w_c | w_z;
            GE: o_cond_ex = (w_n == w_v);
            LT: o_cond_ex = (w_n != w_v);
            GT: o_cond_ex = ~w_z & (w_n == w_v);
            LE: o_cond_ex = w_z | (w_n != w_v);
            AL: o_cond_ex = 1'b1;
            NV: o_cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/condition_unit.sv
// Architectural NZCV register plus condition gating of PC/register/memory writes.
// Conditions are evaluated against the registered flags (previous instruction's
// result); an executing instruction may then update the N,Z and/or C,V groups.
module condition_unit
    import arm_cond_pkg::*;
#(
    parameter nzcv_t RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic [3:0] Flags
);

    nzcv_t r_flags;
    logic  w_cond_ex;
    logic  w_upd;

    cond_check u_cond_check (
        .i_cond    (Cond),
        .i_flags   (r_flags),
        .o_cond_ex (w_cond_ex)
    );

    // Only a retiring, executing instruction may touch the flags.
    assign w_upd = en & w_cond_ex;

    // N,Z group update; reset wins over any same-edge write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_flags[FLAG_N:FLAG_Z] <= RESET_FLAGS[FLAG_N:FLAG_Z];
        else if (w_upd && FlagW[1])
            r_flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
    end

    // C,V group update, independent of the N,Z group.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_flags[FLAG_C:FLAG_V] <= RESET_FLAGS[FLAG_C:FLAG_V];
        else if (w_upd && FlagW[0])
            r_flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
    end

    // Write gating is not qualified by en; the write ports honour en themselves.
    assign CondEx   = w_cond_ex;
    assign PCSrc    = PCS & w_cond_ex;
    assign RegWrite = RegW & w_cond_ex & ~NoWrite;
    assign MemWrite = MemW & w_cond_ex;
    assign Flags    = r_flags;

endmodule
